// File: rtl/n101_icache_ram_ctrl.sv
// I-cache RAM port initiator: arbitrates fetch reads against refill writes onto one
// single-port RAM, returns read data one cycle after issue, and zero-fills the whole
// RAM after reset and on flush.
// Optional light-sleep support is enabled by defining N101_ICACHE_RAM_LS_EN.
module n101_icache_ram_ctrl #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 4,
  parameter int unsigned DP = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          init_done,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [MW-1:0] wr_wem,
  input  logic [DW-1:0] wr_data,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(DP - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          init_done_q, init_done_d;
  logic          rsp_valid_q;
  logic          flush_eff;
  logic          wake_stall;

  assign ram_sd = 1'b0;
  assign ram_ds = 1'b0;

`ifdef N101_ICACHE_RAM_LS_EN
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       flush_pend_q, flush_pend_d;

  assign ram_ls     = (idle_cnt_q == 4'hF);
  // A flush pulse arriving during the wake stall is remembered and serviced next cycle.
  assign flush_eff  = flush | flush_pend_q;
  assign wake_stall = ram_ls & (rd_valid | wr_valid | flush_eff);

  // Idle counter: counts RUN cycles without a RAM access, saturating at 15.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    flush_pend_d = wake_stall & flush;
    if (state_q != StRun || rd_valid || wr_valid || flush_eff) begin
      idle_cnt_d = 4'h0;
    end else if (!ram_cs && idle_cnt_q != 4'hF) begin
      idle_cnt_d = idle_cnt_q + 4'h1;
    end
  end

  // Idle counter and pending-flush registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q   <= 4'h0;
      flush_pend_q <= 1'b0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end
`else
  assign ram_ls     = 1'b0;
  assign flush_eff  = flush;
  assign wake_stall = 1'b0;
`endif

  // Next-state, handshake and RAM drive; priority in RUN is flush > write > read.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rd_ready    = 1'b0;
    wr_ready    = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wem     = '0;
    ram_din     = '0;
    case (state_q)
      StInit: begin
        // Gated by rst_n so the RAM sees no access while reset is held.
        ram_cs     = rst_n;
        ram_we     = rst_n;
        ram_wem    = '1;
        ram_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (flush_eff) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == LastIdx) begin
          state_d     = StRun;
          init_done_d = 1'b1;
          init_cnt_d  = '0;
        end
      end
      StRun: begin
        if (wake_stall) begin
          // Wake-up cycle: the RAM leaves light sleep, nothing is accepted.
        end else if (flush_eff) begin
          state_d     = StInit;
          init_cnt_d  = '0;
          init_done_d = 1'b0;
        end else if (wr_valid) begin
          wr_ready = 1'b1;
          ram_cs   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = wr_addr;
          ram_wem  = wr_wem;
          ram_din  = wr_data;
        end else if (rd_valid) begin
          rd_ready = 1'b1;
          ram_cs   = 1'b1;
          ram_addr = rd_addr;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State, sweep counter and response-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rd_valid & rd_ready;
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_n101_icache_ram_ctrl.sv
// Self-checking bench for n101_icache_ram_ctrl: behavioural RAM, an expected-content
// array updated per accepted write, and directed plus random traffic.
module tb_n101_icache_ram_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned DP = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          init_done;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_wem;
  logic [DW-1:0] wr_data;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_sd;
  logic          ram_ds;
  logic          ram_ls;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram_mem [DP];
  logic [DW-1:0] exp_mem [DP];

  n101_icache_ram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .DP(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .init_done (init_done),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_wem    (wr_wem),
    .wr_data   (wr_data),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wem   (ram_wem),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_sd    (ram_sd),
    .ram_ds    (ram_ds),
    .ram_ls    (ram_ls)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with byte-lane write mask and 1-cycle read.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++) begin
          if (ram_wem[b]) ram_mem[ram_addr % DP][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
      end else begin
        ram_dout <= ram_mem[ram_addr % DP];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] wem);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (wem[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Entered just after a negedge with the sweep at index 0; leaves just after the
  // negedge where init_done must be high.
  task automatic sweep_check(input string tag);
    int bad;
    bad = 0;
    rd_valid = 1'b1;
    wr_valid = 1'b1;
    rd_addr  = $urandom_range(DP - 1);
    wr_addr  = $urandom_range(DP - 1);
    wr_data  = $urandom;
    wr_wem   = 4'hF;
    for (int i = 0; i < DP; i++) begin
      #1;
      if (!(ram_cs === 1'b1 && ram_we === 1'b1 && ram_wem === 4'hF && ram_din === '0 &&
            ram_addr === AW'(i) && rd_ready === 1'b0 && wr_ready === 1'b0 &&
            init_done === 1'b0)) bad++;
      @(negedge clk);
    end
    check({tag, "_sweep_bad_cycles"}, 64'(bad), 64'd0);
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    #1;
    check({tag, "_init_done"}, 64'(init_done), 64'd1);
    for (int i = 0; i < DP; i++) exp_mem[i] = '0;
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data, input logic [MW-1:0] wem);
    wr_valid = 1'b1;
    wr_addr  = AW'(addr);
    wr_data  = data;
    wr_wem   = wem;
    #1;
    for (int k = 0; k < 3 && !wr_ready; k++) begin
      @(negedge clk);
      #1;
    end
    check("wr_ready", 64'(wr_ready), 64'd1);
    check("wr_ram", {ram_cs, ram_we, ram_wem, ram_addr, ram_din[26:0]},
          {1'b1, 1'b1, wem, AW'(addr), data[26:0]});
    exp_mem[addr] = merge(exp_mem[addr], data, wem);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int addr);
    rd_valid = 1'b1;
    rd_addr  = AW'(addr);
    #1;
    for (int k = 0; k < 3 && !rd_ready; k++) begin
      @(negedge clk);
      #1;
    end
    check("rd_ready", 64'(rd_ready), 64'd1);
    check("rd_ram", {ram_cs, ram_we, ram_addr}, {1'b1, 1'b0, AW'(addr)});
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_data", 64'(rsp_data), 64'(exp_mem[addr]));
  endtask

  initial begin
    int wa;
    rst_n    = 1'b0;
    flush    = 1'b0;
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_wem   = '0;
    wr_data  = '0;
    for (int i = 0; i < DP; i++) ram_mem[i] = $urandom;
    #12;
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ram_cs", 64'(ram_cs), 64'd0);
    check("rst_ram_ls", 64'(ram_ls), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("reset");
    check("ram_sd_ds", {ram_sd, ram_ds}, 2'b00);

    // Full-word write then read back.
    do_write(5, 32'hDEAD_BEEF, 4'hF);
    do_read(5);
    check("rsp_deadbeef", 64'(rsp_data), 64'h0000_0000_DEAD_BEEF);

    // Partial-mask write merge.
    do_write(7, 32'hAAAA_AAAA, 4'hF);
    do_write(7, 32'h1234_5678, 4'b0011);
    do_read(7);
    check("rsp_merge", 64'(rsp_data), 64'h0000_0000_AAAA_5678);

    // Simultaneous read and write: write wins, read the next cycle.
    rd_valid = 1'b1;
    rd_addr  = 5;
    wr_valid = 1'b1;
    wr_addr  = 9;
    wr_data  = $urandom;
    wr_wem   = 4'hF;
    #1;
    check("both_ready", {wr_ready, rd_ready, ram_we}, 3'b101);
    exp_mem[9] = wr_data;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("both_rd_next", {rd_ready, ram_cs, ram_we, rsp_valid}, 4'b1100);
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    check("both_rsp", {rsp_valid, rsp_data}, {1'b1, exp_mem[5]});
    do_read(9);

    // Random traffic against the expected-content model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1) == 0) do_write($urandom_range(DP - 1), $urandom, 4'($urandom));
      else do_read($urandom_range(DP - 1));
    end

    // Back-to-back reads: one response per cycle.
    rd_valid = 1'b1;
    rd_addr  = 5;
    @(negedge clk);
    rd_addr  = 7;
    #1;
    check("b2b_rsp0", {rsp_valid, rd_ready, rsp_data}, {2'b11, exp_mem[5]});
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    check("b2b_rsp1", {rsp_valid, rsp_data}, {1'b1, exp_mem[7]});

    // Read then flush: response survives, resweep follows, data gone.
    rd_valid = 1'b1;
    rd_addr  = 5;
    #1;
    check("pre_flush_rd_ready", 64'(rd_ready), 64'd1);
    @(negedge clk);
    rd_valid = 1'b0;
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 3;
    #1;
    check("flush_rsp", {rsp_valid, rsp_data}, {1'b1, exp_mem[5]});
    check("flush_cycle", {rd_ready, wr_ready, ram_cs}, 3'b000);
    @(negedge clk);
    flush    = 1'b0;
    wr_valid = 1'b0;
    sweep_check("flush");
    do_read(5);
    check("post_flush_zero", 64'(rsp_data), 64'd0);

    // Flush in the middle of a sweep restarts it at index 0.
    wa = $urandom_range(DP - 1);
    do_write(wa, $urandom, 4'hF);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    check("mid_sweep_addr", {ram_cs, ram_addr}, {1'b1, AW'(5)});
    @(negedge clk);
    flush = 1'b0;
    sweep_check("restart");
    do_read(wa);

    // Idle period: light sleep only when the feature is built in.
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      #1;
`ifdef N101_ICACHE_RAM_LS_EN
      if (i == 14) check("ls_before", 64'(ram_ls), 64'd0);
`endif
    end
    wr_data = $urandom;
    exp_mem[11] = wr_data;
    ram_mem[11] = wr_data;
    rd_valid = 1'b1;
    rd_addr  = 11;
`ifdef N101_ICACHE_RAM_LS_EN
    check("ls_asleep", 64'(ram_ls), 64'd1);
    #1;
    check("ls_stall", {rd_ready, ram_cs}, 2'b00);
    @(negedge clk);
    #1;
    check("ls_woken", {ram_ls, rd_ready, ram_cs}, 3'b011);
`else
    check("ls_off", 64'(ram_ls), 64'd0);
    #1;
    check("no_stall", {rd_ready, ram_cs}, 2'b11);
`endif
    @(negedge clk);
    rd_valid = 1'b0;
    #1;
    check("wake_rsp", {rsp_valid, rsp_data}, {1'b1, exp_mem[11]});

    // Asynchronous reset with a read in flight drops the response.
    rd_valid = 1'b1;
    rd_addr  = 5;
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    rd_valid = 1'b0;
    #1;
    check("async_rst", {rsp_valid, ram_cs, init_done, ram_ls}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_check("rerst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/n101_icache_ram_ctrl.md
Name: n101_icache_ram_ctrl

Overview:
Initiator side of the I-cache data/tag RAM port (cs/we/addr/wem/din/dout plus sd/ds/ls).
- Arbitrates fetch reads against line-refill writes onto one single-port RAM.
- Returns read data one cycle after issue.
- Runs a zero-fill invalidate sweep after reset and on flush.
- Sits between the I-cache fetch/refill logic and the general RAM instance.

Parameters:
AW, 32, RAM address width; valid entry indices are 0..DP-1
DW, 32, RAM data width
MW, 4, write-enable mask width; each mask bit covers DW/MW data bits
DP, 32, RAM depth in entries; the init sweep covers exactly DP entries

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  one-cycle pulse; starts an invalidate sweep
init_done  output  1  high when no sweep is in progress
rd_valid  input  1  fetch read request
rd_ready  output  1  fetch read accepted
rd_addr  input  AW  fetch read index
rsp_valid  output  1  read data valid; no back-pressure
rsp_data  output  DW  read data
wr_valid  input  1  refill write request
wr_ready  output  1  refill write accepted
wr_addr  input  AW  refill write index
wr_wem  input  MW  refill byte mask
wr_data  input  DW  refill data
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_wem  output  MW  RAM write mask
ram_din  output  DW  RAM write data
ram_dout  input  DW  RAM read data; valid the cycle after a read cs
ram_sd  output  1  shutdown; tied 0
ram_ds  output  1  deep sleep; tied 0
ram_ls  output  1  light sleep (see Optional Feature)

Behaviour:
- Reset values: state=INIT, init_cnt=0, init_done=0, rsp_valid=0, ram_cs=0, ram_ls=0. rsp_data is not reset and its value is don't-care while rsp_valid=0.
- Two states, INIT and RUN.
- INIT:
  - Each cycle: ram_cs=1, ram_we=1, ram_wem=all ones, ram_din=0, ram_addr=init_cnt; then init_cnt++.
  - When init_cnt==DP-1 is written, move to RUN next cycle and set init_done=1 that cycle.
  - rd_ready=0 and wr_ready=0 throughout INIT.
- RUN, fixed priority flush > write > read:
  - flush: move to INIT, clear init_cnt and init_done. rd_ready=0 and wr_ready=0 in the flush cycle. No RAM access is issued that cycle.
  - wr_valid: wr_ready=1. RAM driven with cs=1, we=1, addr=wr_addr, wem=wr_wem, din=wr_data. rd_ready=0.
  - rd_valid with no wr_valid: rd_ready=1. RAM driven with cs=1, we=0, addr=rd_addr. ram_wem=0.
  - Otherwise ram_cs=0.
- ready signals are combinational from valid and state. A transfer occurs when valid&ready.
- Read latency is exactly 1: rsp_valid registers (rd_valid&rd_ready); rsp_data=ram_dout passthrough in the rsp_valid cycle.
- Back-to-back reads give one response per cycle.
- A read accepted in the cycle before a flush still yields its response.
- Flush during INIT restarts the sweep from index 0.
- Requesters must hold valid and payload stable until ready. The block does not check this.
- rd_addr/wr_addr must be < DP. Out-of-range addresses are passed through unchanged, and the result is the RAM's behaviour.
- Async reset mid-sweep or mid-read: outputs return to reset values immediately. Any in-flight response is dropped.

Optional Feature:
Macro N101_ICACHE_RAM_LS_EN.
- Defined:
  - A 4-bit idle counter increments on cycles in RUN with ram_cs=0 and saturates at 15. Any request or flush clears it.
  - ram_ls is asserted while the counter is 15.
  - The first request or flush seen with ram_ls=1 deasserts ram_ls next cycle and is stalled for that one cycle (ready=0, no cs). It is serviced in the following cycle per normal priority.
- Not defined: ram_ls tied 0, no idle counter, no wake stall.

Test Plan:
- Reset release with DP=32 -> 32 consecutive writes of din=0 to addr 0..31, wem=4'hF; init_done rises on cycle 33; no rd_ready/wr_ready before that.
- Write addr 5 data 32'hDEAD_BEEF wem 4'hF, then read addr 5 -> rsp_valid exactly 1 cycle after the read handshake with rsp_data=32'hDEAD_BEEF.
- rd_valid and wr_valid asserted together -> write taken first (wr_ready=1, rd_ready=0), read taken next cycle, rsp one cycle later.
- Write wem 4'b0011 data 32'h1234_5678 over 32'hAAAA_AAAA at addr 7 -> read returns 32'hAAAA_5678.
- Read handshake at cycle N, flush at N+1 -> rsp_valid at N+1 with correct data; full 32-entry resweep follows; a subsequent read of the earlier written address returns 0.
- With N101_ICACHE_RAM_LS_EN: 15 idle cycles -> ram_ls=1; rd_valid then -> one stall cycle with ram_ls falling, read issued the next cycle. Without the macro, ram_ls stays 0 and there is no stall.
